// File: rtl/instr_prefetch_buf_pkg.sv
// prefetch_pkg: downstream handshake states and default widths for instr_prefetch_buf.
package prefetch_pkg;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_RTZ} dn_state_e;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_W    = 8;
endpackage

// File: rtl/instr_prefetch_buf_if.sv
// instr_prefetch_buf_if: fetch-side and decode-side 4-phase handshakes plus flush/level.
interface instr_prefetch_buf_if
    import prefetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W    = DEF_PC_W
);
    localparam int LW = $clog2(DEPTH + 1);
    logic               up_req;
    logic               up_ack;
    logic [INSTR_W-1:0] up_instr;
    logic [PC_W-1:0]    up_pc;
    logic               dn_req;
    logic               dn_ack;
    logic [INSTR_W-1:0] dn_instr;
    logic [PC_W-1:0]    dn_pc;
    logic               flush;
    logic [LW-1:0]      level;
    modport master (
        output up_req, up_instr, up_pc, dn_ack, flush,
        input  up_ack, dn_req, dn_instr, dn_pc, level
    );
    modport slave (
        input  up_req, up_instr, up_pc, dn_ack, flush,
        output up_ack, dn_req, dn_instr, dn_pc, level
    );
endinterface

// File: rtl/instr_prefetch_buf_hs_sync2.sv
// hs_sync2: 2-flop synchronizer for a handshake level signal, async active-low reset to 0.
module hs_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], d_i};
    end
    assign q_o = sync_q[1];
endmodule

// File: rtl/instr_prefetch_buf.sv
// instr_prefetch_buf: FIFO between fetch and decode with 4-phase handshakes on both sides.
// Define PREFETCH_SYNC_EN to pass up_req and dn_ack through 2-flop synchronizers.
module instr_prefetch_buf
    import prefetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W    = DEF_PC_W
) (
    input logic clk,
    input logic rst_n,
    instr_prefetch_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic up_req_s;
    logic dn_ack_s;
`ifdef PREFETCH_SYNC_EN
    hs_sync2 u_sync_up (.clk(clk), .rst_n(rst_n), .d_i(bus.up_req), .q_o(up_req_s));
    hs_sync2 u_sync_dn (.clk(clk), .rst_n(rst_n), .d_i(bus.dn_ack), .q_o(dn_ack_s));
`else
    assign up_req_s = bus.up_req;
    assign dn_ack_s = bus.dn_ack;
`endif

    dn_state_e          state_q, state_d;
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];
    logic [PC_W-1:0]    mem_pc_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               up_ack_q, up_ack_d;
    logic               dn_req_q, dn_req_d;
    logic               drop_q, drop_d;
    logic [INSTR_W-1:0] dn_instr_q, dn_instr_d;
    logic [PC_W-1:0]    dn_pc_q, dn_pc_d;
    logic               capture, write, pop;

    // A capture under flush still acks so the fetch handshake completes; only the write is lost.
    assign capture  = up_req_s && !up_ack_q && (level_q != FULL);
    assign write    = capture && !bus.flush;
    assign up_ack_d = capture || (up_ack_q && up_req_s);

    // drop_q marks an offered word whose FIFO slot was already cleared by a flush.
    always_comb begin
        state_d    = state_q;
        dn_req_d   = dn_req_q;
        dn_instr_d = dn_instr_q;
        dn_pc_d    = dn_pc_q;
        drop_d     = drop_q;
        pop        = 1'b0;
        case (state_q)
            D_IDLE: begin
                if (level_q != '0 && !dn_ack_s && !bus.flush) begin
                    state_d    = D_REQ;
                    dn_req_d   = 1'b1;
                    dn_instr_d = mem_instr_q[rd_ptr_q];
                    dn_pc_d    = mem_pc_q[rd_ptr_q];
                    drop_d     = 1'b0;
                end
            end
            D_REQ: begin
                if (dn_ack_s) begin
                    state_d  = D_RTZ;
                    dn_req_d = 1'b0;
                    pop      = !bus.flush && !drop_q;
                    drop_d   = 1'b0;
                end else if (bus.flush) begin
                    drop_d = 1'b1;
                end
            end
            D_RTZ: begin
                if (!dn_ack_s) state_d = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

    assign level_d  = bus.flush ? '0 : level_q + LW'(write) - LW'(pop);
    assign wr_ptr_d = bus.flush ? '0 : wr_ptr_q + AW'(write);
    assign rd_ptr_d = bus.flush ? '0 : rd_ptr_q + AW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= D_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            up_ack_q   <= 1'b0;
            dn_req_q   <= 1'b0;
            drop_q     <= 1'b0;
            dn_instr_q <= '0;
            dn_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            up_ack_q   <= up_ack_d;
            dn_req_q   <= dn_req_d;
            drop_q     <= drop_d;
            dn_instr_q <= dn_instr_d;
            dn_pc_q    <= dn_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (write) begin
            mem_instr_q[wr_ptr_q] <= bus.up_instr;
            mem_pc_q[wr_ptr_q]    <= bus.up_pc;
        end
    end

    assign bus.up_ack   = up_ack_q;
    assign bus.dn_req   = dn_req_q;
    assign bus.dn_instr = dn_instr_q;
    assign bus.dn_pc    = dn_pc_q;
    assign bus.level    = level_q;
endmodule

// File: tb/tb_instr_prefetch_buf.sv
// tb_instr_prefetch_buf: directed and randomized checks of the prefetch buffer against a word-queue model.
module tb_instr_prefetch_buf;
    localparam int DEPTH = 4;
`ifdef PREFETCH_SYNC_EN
    localparam int SY = 2;
`else
    localparam int SY = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [39:0] exp_q [$];

    instr_prefetch_buf_if #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(8)) bus ();
    instr_prefetch_buf #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        return (which == 0) ? bus.up_ack : bus.dn_req;
    endfunction

    task automatic wait_sig(input int which, input logic val, input string tag);
        int n = 0;
        while (sig(which) !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(sig(which)), 64'(val));
    endtask

    task automatic push_word(input logic [31:0] instr, input logic [7:0] pc);
        bus.up_instr = instr;
        bus.up_pc    = pc;
        bus.up_req   = 1'b1;
        wait_sig(0, 1'b1, "push_ack_rise");
        exp_q.push_back({instr, pc});
        bus.up_req = 1'b0;
        wait_sig(0, 1'b0, "push_ack_fall");
    endtask

    task automatic pop_check(input string tag);
        logic [39:0] got;
        logic [39:0] want;
        wait_sig(1, 1'b1, "pop_req_rise");
        got = {bus.dn_instr, bus.dn_pc};
        if (exp_q.size() > 0) want = exp_q.pop_front();
        else want = 'x;
        bus.dn_ack = 1'b1;
        wait_sig(1, 1'b0, "pop_req_fall");
        bus.dn_ack = 1'b0;
        check(tag, 64'(got), 64'(want));
    endtask

    initial begin
        int ua;
        int dr;
        logic [39:0] head;
        logic [7:0] npc;
        bus.up_req = 1'b0; bus.up_instr = '0; bus.up_pc = '0; bus.dn_ack = 1'b0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_up_ack", 64'(bus.up_ack), 64'(0));
        check("rst_dn_req", 64'(bus.dn_req), 64'(0));
        check("rst_dn_instr", 64'(bus.dn_instr), 64'(0));
        check("rst_dn_pc", 64'(bus.dn_pc), 64'(0));
        check("rst_level", 64'(bus.level), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // single word: ack after 1 edge, offer 2 edges after the request
        bus.up_instr = 32'h0000_1234; bus.up_pc = 8'h10; bus.up_req = 1'b1;
        ua = -1; dr = -1;
        for (int c = 1; c <= 12 && dr < 0; c++) begin
            @(negedge clk);
            if (ua < 0 && bus.up_ack) begin ua = c; bus.up_req = 1'b0; end
            if (dr < 0 && bus.dn_req) dr = c;
        end
        check("single_up_ack_latency", 64'(ua), 64'(1 + SY));
        check("single_dn_req_latency", 64'(dr), 64'(2 + SY));
        check("single_dn_instr", 64'(bus.dn_instr), 64'h1234);
        check("single_dn_pc", 64'(bus.dn_pc), 64'h10);
        bus.dn_ack = 1'b1;
        wait_sig(1, 1'b0, "single_dn_req_fall");
        bus.dn_ack = 1'b0;
        repeat (2 + SY) @(negedge clk);
        check("single_level_empty", 64'(bus.level), 64'(0));
        check("single_up_ack_low", 64'(bus.up_ack), 64'(0));

        // fill with decode stalled; fifth word waits for a pop
        for (int i = 0; i < 4; i++) push_word($urandom, 8'(i));
        check("fill_level_full", 64'(bus.level), 64'(DEPTH));
        check("fill_head_pc", 64'(bus.dn_pc), 64'h00);
        bus.up_instr = $urandom; bus.up_pc = 8'h04; bus.up_req = 1'b1;
        repeat (6 + SY) @(negedge clk);
        check("fill_5th_no_ack", 64'(bus.up_ack), 64'(0));
        check("fill_level_hold", 64'(bus.level), 64'(DEPTH));
        pop_check("fill_pop0");
        wait_sig(0, 1'b1, "fill_5th_ack");
        exp_q.push_back({bus.up_instr, bus.up_pc});
        bus.up_req = 1'b0;
        wait_sig(0, 1'b0, "fill_5th_rtz");
        for (int i = 1; i <= 4; i++) pop_check("fill_order");
        check("fill_level_drained", 64'(bus.level), 64'(0));

        // flush with pc 0x20 committed in D_REQ
        push_word($urandom, 8'h20);
        push_word($urandom, 8'h21);
        push_word($urandom, 8'h22);
        check("flush_pre_dn_req", 64'(bus.dn_req), 64'(1));
        check("flush_pre_dn_pc", 64'(bus.dn_pc), 64'h20);
        head = exp_q[0];
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        exp_q.delete();
        exp_q.push_back(head);
        check("flush_level_zero", 64'(bus.level), 64'(0));
        check("flush_dn_req_held", 64'(bus.dn_req), 64'(1));
        pop_check("flush_committed_word");
        repeat (6 + SY) @(negedge clk);
        check("flush_no_more_req", 64'(bus.dn_req), 64'(0));
        check("flush_level_after_pop", 64'(bus.level), 64'(0));
        push_word($urandom, 8'h40);
        pop_check("flush_new_word");

        // flush on the capture edge of pc 0x30
        bus.up_instr = $urandom; bus.up_pc = 8'h30; bus.up_req = 1'b1;
        repeat (SY) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fcap_up_ack", 64'(bus.up_ack), 64'(1));
        check("fcap_level", 64'(bus.level), 64'(0));
        bus.up_req = 1'b0;
        wait_sig(0, 1'b0, "fcap_rtz");
        repeat (6 + SY) @(negedge clk);
        check("fcap_never_offered", 64'(bus.dn_req), 64'(0));
        push_word($urandom, 8'h41);
        pop_check("fcap_next_word");

        // concurrent push and pop at level 2, ten times around the pointers
        push_word($urandom, 8'h50);
        push_word($urandom, 8'h51);
        wait_sig(1, 1'b1, "conc_first_req");
        for (int i = 0; i < 10; i++) begin
            check("conc_offer", 64'({bus.dn_instr, bus.dn_pc}), 64'(exp_q[0]));
            npc = 8'(8'h52 + i);
            bus.up_instr = $urandom; bus.up_pc = npc;
            bus.up_req = 1'b1; bus.dn_ack = 1'b1;
            repeat (1 + SY) @(negedge clk);
            check("conc_up_ack", 64'(bus.up_ack), 64'(1));
            check("conc_dn_req_low", 64'(bus.dn_req), 64'(0));
            check("conc_level", 64'(bus.level), 64'(2));
            void'(exp_q.pop_front());
            exp_q.push_back({bus.up_instr, npc});
            bus.up_req = 1'b0; bus.dn_ack = 1'b0;
            wait_sig(0, 1'b0, "conc_up_rtz");
            wait_sig(1, 1'b1, "conc_next_req");
        end
        pop_check("conc_drain");
        pop_check("conc_drain");
        check("conc_level_end", 64'(bus.level), 64'(0));

        // randomized producer/consumer
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    push_word($urandom, 8'(8'h80 + i));
                end
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    check("rnd_level_bound", 64'(bus.level > 3'(DEPTH)), 64'(0));
                    pop_check("rnd_word");
                end
            end
        join
        repeat (3 + SY) @(negedge clk);
        check("rnd_level_end", 64'(bus.level), 64'(0));
        check("rnd_queue_end", 64'(exp_q.size()), 64'(0));

        // reset mid-handshake
        push_word($urandom, 8'h60);
        wait_sig(1, 1'b1, "rst_mid_dn_req");
        bus.up_instr = $urandom; bus.up_pc = 8'h61; bus.up_req = 1'b1;
        wait_sig(0, 1'b1, "rst_mid_up_ack");
        rst_n = 1'b0;
        #1;
        check("rst_mid_up_ack_low", 64'(bus.up_ack), 64'(0));
        check("rst_mid_dn_req_low", 64'(bus.dn_req), 64'(0));
        check("rst_mid_dn_instr", 64'(bus.dn_instr), 64'(0));
        check("rst_mid_dn_pc", 64'(bus.dn_pc), 64'(0));
        check("rst_mid_level", 64'(bus.level), 64'(0));
        bus.up_req = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4 + SY) @(negedge clk);
        check("rst_after_dn_req", 64'(bus.dn_req), 64'(0));
        check("rst_after_level", 64'(bus.level), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
